selfdestruct_seq: RTL and testbench
===================================

# selfdestruct_seq

Sequencing controller for the self-destruct countdown datapath. It votes the three hazard switches (2-of-3) and arms the countdown only after the threat persists for a confirmation window. It then steps the 4-bit countdown on 1 s tick strobes and latches a terminal detonated state that drives all LEDs. It sits between the debounced switch outputs and the LED pins, running on the main clock with a tick enable rather than a divided clock.

## Interface
- `COUNT_MAX`, default 10: last countdown value before detonation; must be ≤ 14.
- `ARM_TICKS`, default 3: consecutive ticks of sustained threat required to arm; must be ≥ 1 and ≤ 15.
- `clk`, in, 1: main clock; all logic on posedge.
- `reset`, in, 1: synchronous, active-high; dominates every other input.
- `tick`, in, 1: one-cycle strobe, 1 Hz.
- `in_combat`, in, 1: debounced combat switch; low disarms.
- `danger`, in, 1: debounced hazard switch.
- `damaged`, in, 1: debounced hazard switch.
- `immobilized`, in, 1: debounced hazard switch.
- `abort_req`, in, 1: abort request level. Only present with `SELFDESTRUCT_ABORT_EN`.
- `abort_ack`, out, 1: one-cycle abort acknowledge. Only present with `SELFDESTRUCT_ABORT_EN`.
- `state`, out, 3: current FSM state encoding.
- `cnt`, out, 4: countdown value.
- `leds`, out, 4: LED drive.
- `boom`, out, 1: one-cycle detonation pulse.

## Operation
- `threat_q` is a register holding (danger&damaged)|(danger&immobilized)|(damaged&immobilized). It adds 1 cycle of latency.
- State encodings: IDLE=0, ARMING=1, COUNTING=2, DETONATED=3, ABORTED=4.
- **IDLE**
  - `in_combat & threat_q` -> ARMING, with `arm_cnt`=0.
  - `tick` is ignored.
- **ARMING**
  - `!in_combat | !threat_q` -> IDLE, with `arm_cnt`=0.
  - Otherwise, on `tick`: if `arm_cnt`==ARM_TICKS-1 -> COUNTING with `cnt`=0; else `arm_cnt`++.
- **COUNTING**
  - `!in_combat` -> IDLE with `cnt`=0.
  - Otherwise, on `tick`: if `cnt`==COUNT_MAX -> DETONATED with `boom`=1; else `cnt`++.
  - Loss of `threat_q` does NOT stop the count; the countdown is committed once started.
- **DETONATED**
  - Absorbing state; exit only via `reset`.
  - `cnt` frozen at COUNT_MAX.
  - All inputs ignored.
- **ABORTED** (macro only)
  - Entered from ARMING or COUNTING when `abort_req`=1.
  - `cnt` is held; `abort_ack`=1 on the entry cycle only.
  - Stays until `in_combat`=0 -> IDLE with `cnt`=0.
- `leds` = 4'b1111 in DETONATED, otherwise `cnt`.
- Priority within a cycle, highest first: `reset` > `!in_combat` > `abort_req` > `tick`.
- `cnt` never exceeds COUNT_MAX and never wraps. The value 4'b1111 is reserved for the detonated display.

## Timing
- Reset values:
  - `state`=IDLE.
  - `cnt`=0, `arm_cnt`=0, `threat_q`=0.
  - `leds`=0, `boom`=0, `abort_ack`=0.
- All outputs are registered and update on the clock edge after the causing input or `tick` is sampled.
- Switch-to-ARMING latency is 2 cycles: 1 cycle for the vote register, 1 cycle for the FSM.
- Tick count from ARMING entry to `boom` is ARM_TICKS + COUNT_MAX + 1; the default is 14 ticks.
- `boom` and the DETONATED state become visible on the same edge. `leds` reads 1111 from that edge onward.
- A `tick` arriving in the same cycle as IDLE->ARMING is not counted.
- `reset` asserted in any state, including DETONATED, returns the block to IDLE on the next edge.
- `abort_req` is a level signal:
  - `abort_ack` pulses exactly once per ABORTED entry.
  - A request held through ABORTED->IDLE->ARMING re-aborts immediately.

## Configuration
- Macro: `SELFDESTRUCT_ABORT_EN`.
- Defined:
  - `abort_req` and `abort_ack` ports exist.
  - ABORTED state is reachable.
- Undefined:
  - Both ports are absent.
  - ABORTED is unreachable and the encoding 4 is never produced.
  - Only `in_combat` or `reset` can stop a countdown.

## Test plan
- Reset, then `danger`=`damaged`=1 with `in_combat`=1, then 14 ticks.
  - `cnt` steps 0..10.
  - `boom` pulses once on the 14th tick.
  - `leds`=1111 and `state`=3 thereafter.
- Only `danger`=1 with `in_combat`=1, 20 ticks -> `state` stays 0, `leds`=0000.
- Armed, then `threat_q` dropped after 1 tick -> IDLE, `cnt`=0. Separately, `threat_q` dropped in COUNTING at `cnt`=5 -> counting continues to detonation.
- COUNTING at `cnt`=6, then `in_combat`=0 in the same cycle as `tick` -> IDLE, `cnt`=0, no increment.
- DETONATED, then `in_combat` toggled and ticks applied -> unchanged. Then `reset`=1 for 1 cycle -> all outputs 0, `state`=0.
- With the macro defined: `abort_req`=1 at `cnt`=4 -> `state`=4, `abort_ack` high for 1 cycle, `cnt` held at 4. Then `in_combat`=0 -> IDLE, `cnt`=0.

Source files
------------

// File: rtl/selfdestruct_seq_if.sv
// ---------------------------------------------------------------------------
// selfdestruct_seq_if
//
// Purpose: bundles the switch inputs, tick strobe and display/detonation
// outputs of the self-destruct sequencer into one port.
//
// Signals:
//   tick         1  one-cycle 1 Hz strobe (to sequencer)
//   in_combat    1  debounced combat switch; low disarms (to sequencer)
//   danger       1  debounced hazard switch (to sequencer)
//   damaged      1  debounced hazard switch (to sequencer)
//   immobilized  1  debounced hazard switch (to sequencer)
//   abort_req    1  abort request level (to sequencer, SELFDESTRUCT_ABORT_EN)
//   abort_ack    1  one-cycle abort acknowledge (from sequencer, SELFDESTRUCT_ABORT_EN)
//   state        3  FSM state encoding (from sequencer)
//   cnt          4  countdown value (from sequencer)
//   leds         4  LED drive (from sequencer)
//   boom         1  one-cycle detonation pulse (from sequencer)
//
// Modports:
//   master - the side driving the switches and tick (testbench / switch logic)
//   slave  - the sequencer itself
//
// Configuration macro: SELFDESTRUCT_ABORT_EN adds abort_req / abort_ack.
// ---------------------------------------------------------------------------
interface selfdestruct_seq_if;
  logic       tick;
  logic       in_combat;
  logic       danger;
  logic       damaged;
  logic       immobilized;
`ifdef SELFDESTRUCT_ABORT_EN
  logic       abort_req;
  logic       abort_ack;
`endif
  logic [2:0] state;
  logic [3:0] cnt;
  logic [3:0] leds;
  logic       boom;

  modport master (
`ifdef SELFDESTRUCT_ABORT_EN
    output abort_req,
    input  abort_ack,
`endif
    output tick,
    output in_combat,
    output danger,
    output damaged,
    output immobilized,
    input  state,
    input  cnt,
    input  leds,
    input  boom
  );

  modport slave (
`ifdef SELFDESTRUCT_ABORT_EN
    input  abort_req,
    output abort_ack,
`endif
    input  tick,
    input  in_combat,
    input  danger,
    input  damaged,
    input  immobilized,
    output state,
    output cnt,
    output leds,
    output boom
  );
endinterface

// File: rtl/selfdestruct_seq.sv
// ---------------------------------------------------------------------------
// selfdestruct_seq
//
// Purpose: sequencing controller for the self-destruct countdown. Votes the
// three hazard switches 2-of-3 into a registered threat flag, arms after the
// threat persists for ARM_TICKS ticks, counts 0..COUNT_MAX on 1 Hz ticks and
// then latches a terminal DETONATED state that lights every LED. Runs on the
// main clock; tick is an enable strobe, not a clock.
//
// Parameters:
//   COUNT_MAX  last countdown value before detonation (<= 14; 4'hF is
//              reserved for the detonated display)
//   ARM_TICKS  consecutive ticks of sustained threat needed to arm (1..15)
//
// Ports:
//   clk    main clock, all logic on posedge
//   reset  synchronous active-high reset, dominates every other input
//   bus    selfdestruct_seq_if.slave: switches, tick, state/cnt/leds/boom
//          (and abort_req/abort_ack when the abort feature is built)
//
// Configuration macro: SELFDESTRUCT_ABORT_EN enables the ABORTED state and
// the abort_req/abort_ack signals. Without it only in_combat or reset can
// stop a countdown and encoding 4 is never produced.
// ---------------------------------------------------------------------------
module selfdestruct_seq #(
  parameter int COUNT_MAX = 10,
  parameter int ARM_TICKS = 3
) (
  input  logic              clk,
  input  logic              reset,
  selfdestruct_seq_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ARMING    = 3'd1,
    S_COUNTING  = 3'd2,
    S_DETONATED = 3'd3,
    S_ABORTED   = 3'd4
  } state_t;

  localparam logic [3:0] CNT_LAST = 4'(COUNT_MAX);
  localparam logic [3:0] ARM_LAST = 4'(ARM_TICKS - 1);

  state_t     r_state;
  logic [3:0] r_cnt;
  logic [3:0] r_arm_cnt;
  logic       r_threat_q;
  logic [3:0] r_leds;
  logic       r_boom;
  logic       r_abort_ack;

  state_t     w_state_next;
  logic [3:0] w_cnt_next;
  logic [3:0] w_arm_cnt_next;
  logic [3:0] w_leds_next;
  logic       w_boom_next;
  logic       w_abort_ack_next;
  logic       w_vote;
  logic       w_abort;

  // 2-of-3 majority of the hazard switches
  assign w_vote = (bus.danger & bus.damaged) |
                  (bus.danger & bus.immobilized) |
                  (bus.damaged & bus.immobilized);

`ifdef SELFDESTRUCT_ABORT_EN
  assign w_abort = bus.abort_req;
`else
  assign w_abort = 1'b0;
`endif

  // Next-state / next-output logic
  always_comb begin
    w_state_next     = r_state;
    w_cnt_next       = r_cnt;
    w_arm_cnt_next   = r_arm_cnt;
    w_boom_next      = 1'b0;
    w_abort_ack_next = 1'b0;

    case (r_state)
      S_IDLE: begin
        // tick is deliberately ignored here, so a tick coinciding with
        // the arming transition is never counted
        if (bus.in_combat && r_threat_q) begin
          w_state_next   = S_ARMING;
          w_arm_cnt_next = 4'd0;
        end
      end

      S_ARMING: begin
        if (!bus.in_combat || !r_threat_q) begin
          w_state_next   = S_IDLE;
          w_arm_cnt_next = 4'd0;
        end else if (w_abort) begin
          w_state_next     = S_ABORTED;
          w_abort_ack_next = 1'b1;
        end else if (bus.tick) begin
          if (r_arm_cnt == ARM_LAST) begin
            w_state_next   = S_COUNTING;
            w_cnt_next     = 4'd0;
            w_arm_cnt_next = 4'd0;
          end else begin
            w_arm_cnt_next = r_arm_cnt + 4'd1;
          end
        end
      end

      S_COUNTING: begin
        // Threat loss does not stop a committed countdown; only the combat
        // switch (or abort) does.
        if (!bus.in_combat) begin
          w_state_next = S_IDLE;
          w_cnt_next   = 4'd0;
        end else if (w_abort) begin
          w_state_next     = S_ABORTED;
          w_abort_ack_next = 1'b1;
        end else if (bus.tick) begin
          if (r_cnt == CNT_LAST) begin
            w_state_next = S_DETONATED;
            w_boom_next  = 1'b1;
          end else begin
            w_cnt_next = r_cnt + 4'd1;
          end
        end
      end

      S_DETONATED: begin
        // absorbing; only reset leaves
        w_cnt_next = CNT_LAST;
      end

`ifdef SELFDESTRUCT_ABORT_EN
      S_ABORTED: begin
        // cnt held until the combat switch is released
        if (!bus.in_combat) begin
          w_state_next = S_IDLE;
          w_cnt_next   = 4'd0;
        end
      end
`endif

      default: begin
        // unused encodings recover to IDLE
        w_state_next   = S_IDLE;
        w_cnt_next     = 4'd0;
        w_arm_cnt_next = 4'd0;
      end
    endcase

    // LEDs show the count, or all-on once detonated (4'hF never a count)
    w_leds_next = (w_state_next == S_DETONATED) ? 4'hF : w_cnt_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= 4'd0;
      r_arm_cnt   <= 4'd0;
      r_threat_q  <= 1'b0;
      r_leds      <= 4'd0;
      r_boom      <= 1'b0;
      r_abort_ack <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_cnt       <= w_cnt_next;
      r_arm_cnt   <= w_arm_cnt_next;
      r_threat_q  <= w_vote;
      r_leds      <= w_leds_next;
      r_boom      <= w_boom_next;
      r_abort_ack <= w_abort_ack_next;
    end
  end

  assign bus.state = r_state;
  assign bus.cnt   = r_cnt;
  assign bus.leds  = r_leds;
  assign bus.boom  = r_boom;
`ifdef SELFDESTRUCT_ABORT_EN
  assign bus.abort_ack = r_abort_ack;
`endif

endmodule

// File: tb/tb_selfdestruct_seq.sv
// ---------------------------------------------------------------------------
// tb_selfdestruct_seq
//
// Directed bench for selfdestruct_seq with default parameters
// (COUNT_MAX=10, ARM_TICKS=3). Expected values are hand-derived.
// Abort scenarios are exercised when SELFDESTRUCT_ABORT_EN is defined.
// ---------------------------------------------------------------------------
module tb_selfdestruct_seq;
  logic clk;
  logic reset;
  int   checks;
  int   errors;
  int   tick_no;

  selfdestruct_seq_if bus ();

  selfdestruct_seq #(
    .COUNT_MAX (10),
    .ARM_TICKS (3)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // one idle cycle, then one cycle with tick high; sampled #1 after the edge
  task automatic pulse_tick();
    step(1);
    bus.tick = 1'b1;
    step(1);
    bus.tick = 1'b0;
    tick_no++;
    $display("tick %0d state=%0d cnt=%0d leds=%b boom=%b",
             tick_no, bus.state, bus.cnt, bus.leds, bus.boom);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(1);
    reset = 1'b0;
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    tick_no     = 0;
    reset       = 1'b1;
    bus.tick        = 1'b0;
    bus.in_combat   = 1'b0;
    bus.danger      = 1'b0;
    bus.damaged     = 1'b0;
    bus.immobilized = 1'b0;
`ifdef SELFDESTRUCT_ABORT_EN
    bus.abort_req   = 1'b0;
`endif
    step(2);
    reset = 1'b0;

    // reset state
    check("rst_state", 32'(bus.state), 0);
    check("rst_cnt",   32'(bus.cnt),   0);
    check("rst_leds",  32'(bus.leds),  0);
    check("rst_boom",  32'(bus.boom),  0);

    // single hazard switch never arms
    bus.in_combat = 1'b1;
    bus.danger    = 1'b1;
    for (int i = 0; i < 20; i++) pulse_tick();
    check("one_sw_state", 32'(bus.state), 0);
    check("one_sw_leds",  32'(bus.leds),  0);

    // two switches: 2-cycle latency to ARMING
    bus.damaged = 1'b1;
    step(1);
    check("arm_lat1", 32'(bus.state), 0);
    step(1);
    check("arm_lat2", 32'(bus.state), 1);

    // 14 ticks to detonation
    for (int k = 1; k <= 14; k++) begin
      int es, ec;
      es = (k < 3) ? 1 : (k < 14) ? 2 : 3;
      ec = (k < 3) ? 0 : (k < 14) ? k - 3 : 10;
      pulse_tick();
      check($sformatf("run_state_%0d", k), 32'(bus.state), 32'(es));
      check($sformatf("run_cnt_%0d", k),   32'(bus.cnt),   32'(ec));
      check($sformatf("run_leds_%0d", k),  32'(bus.leds),  (k == 14) ? 32'hF : 32'(ec));
      check($sformatf("run_boom_%0d", k),  32'(bus.boom),  (k == 14) ? 32'd1 : 32'd0);
    end
    step(1);
    check("boom_one_cycle", 32'(bus.boom), 0);

    // DETONATED ignores inputs
    bus.in_combat = 1'b0;
    pulse_tick();
    pulse_tick();
    bus.in_combat = 1'b1;
    pulse_tick();
    pulse_tick();
    check("det_state", 32'(bus.state), 3);
    check("det_cnt",   32'(bus.cnt),   10);
    check("det_leds",  32'(bus.leds),  32'hF);
    check("det_boom",  32'(bus.boom),  0);

    // single-cycle reset from DETONATED
    do_reset();
    check("det_rst_state", 32'(bus.state), 0);
    check("det_rst_cnt",   32'(bus.cnt),   0);
    check("det_rst_leds",  32'(bus.leds),  0);
    check("det_rst_boom",  32'(bus.boom),  0);

    // arm, then lose threat after one tick -> IDLE, arm count cleared
    step(2);
    check("rearm_state", 32'(bus.state), 1);
    pulse_tick();
    check("arm_1tick", 32'(bus.state), 1);
    bus.damaged = 1'b0;
    step(2);
    check("drop_arm_state", 32'(bus.state), 0);
    check("drop_arm_cnt",   32'(bus.cnt),   0);
    bus.damaged = 1'b1;
    step(2);
    check("arm_again", 32'(bus.state), 1);
    pulse_tick();
    pulse_tick();
    check("arm_cnt_cleared", 32'(bus.state), 1);
    pulse_tick();
    check("count_start_state", 32'(bus.state), 2);
    check("count_start_cnt",   32'(bus.cnt),   0);

    // threat lost in COUNTING at cnt=5 -> countdown continues
    for (int i = 0; i < 5; i++) pulse_tick();
    check("cnt5", 32'(bus.cnt), 5);
    bus.danger  = 1'b0;
    bus.damaged = 1'b0;
    step(2);
    check("nothreat_state", 32'(bus.state), 2);
    check("nothreat_cnt",   32'(bus.cnt),   5);
    for (int i = 0; i < 5; i++) pulse_tick();
    check("nothreat_cnt10", 32'(bus.cnt), 10);
    check("nothreat_st10",  32'(bus.state), 2);
    pulse_tick();
    check("nothreat_det",  32'(bus.state), 3);
    check("nothreat_boom", 32'(bus.boom),  1);

    // tick on the IDLE->ARMING cycle is not counted
    do_reset();
    bus.danger  = 1'b1;
    bus.damaged = 1'b1;
    step(1);
    bus.tick = 1'b1;
    step(1);
    bus.tick = 1'b0;
    check("tick_on_arm_state", 32'(bus.state), 1);
    pulse_tick();
    pulse_tick();
    check("tick_on_arm_ignored", 32'(bus.state), 1);
    pulse_tick();
    check("tick_on_arm_count", 32'(bus.state), 2);

    // in_combat drop coinciding with tick at cnt=6 -> IDLE, no increment
    for (int i = 0; i < 6; i++) pulse_tick();
    check("cnt6", 32'(bus.cnt), 6);
    step(1);
    bus.in_combat = 1'b0;
    bus.tick      = 1'b1;
    step(1);
    bus.tick      = 1'b0;
    check("disarm_state", 32'(bus.state), 0);
    check("disarm_cnt",   32'(bus.cnt),   0);
    check("disarm_leds",  32'(bus.leds),  0);

`ifdef SELFDESTRUCT_ABORT_EN
    // abort at cnt=4
    bus.in_combat = 1'b1;
    step(2);
    check("ab_arm", 32'(bus.state), 1);
    for (int i = 0; i < 3; i++) pulse_tick();
    for (int i = 0; i < 4; i++) pulse_tick();
    check("ab_cnt4", 32'(bus.cnt), 4);
    bus.abort_req = 1'b1;
    step(1);
    check("ab_state", 32'(bus.state),     4);
    check("ab_ack",   32'(bus.abort_ack), 1);
    check("ab_cnt",   32'(bus.cnt),       4);
    step(1);
    check("ab_ack_once", 32'(bus.abort_ack), 0);
    pulse_tick();
    check("ab_hold_cnt",   32'(bus.cnt),   4);
    check("ab_hold_state", 32'(bus.state), 4);
    bus.in_combat = 1'b0;
    step(1);
    check("ab_exit_state", 32'(bus.state), 0);
    check("ab_exit_cnt",   32'(bus.cnt),   0);
    // held request re-aborts as soon as ARMING is re-entered
    bus.in_combat = 1'b1;
    step(1);
    check("ab_rearm", 32'(bus.state), 1);
    step(1);
    check("ab_reabort_state", 32'(bus.state),     4);
    check("ab_reabort_ack",   32'(bus.abort_ack), 1);
    bus.abort_req = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
